// File: rtl/uart_core_param_if.sv
// uart_core_param_if: peripheral register bus between a bus master and the UART.
// One-cycle write/read strobes; read data returns on the following cycle.
interface uart_core_param_if;
    logic [11:0] reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [31:0] reg_rdata;

    modport master (
        output reg_addr, reg_wdata, reg_we, reg_re,
        input  reg_rdata
    );
    modport slave (
        input  reg_addr, reg_wdata, reg_we, reg_re,
        output reg_rdata
    );
endinterface

// File: rtl/uart_core_param.sv
// uart_core_param: register-mapped full-duplex UART, TX/RX FIFOs, interrupts.
// Parity generation/checking is built only when UART_PARITY_EN is defined.
module uart_core_param #(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 8,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    uart_core_param_if.slave bus,
    input  logic             rx_i,
    output logic             tx_o,
    output logic             intr_tx_wm,
    output logic             intr_rx_wm,
    output logic             intr_rx_timeout,
    output logic             intr_rx_err,
    output logic             intr_tx_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_BITS + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} st_t;

    logic [15:0] div_q;
    logic        tx_en_q, rx_en_q, tmo_q, err_q;
    logic [5:0]  tx_wm_q, rx_wm_q;
    logic [4:0]  ien_q;
    logic [31:0] rd_val, rdata_q;

    logic a_div, a_tx, a_rx, a_ctrl, a_wm, a_stat, a_ien, a_ist;
    assign a_div  = bus.reg_addr == 12'h000;
    assign a_tx   = bus.reg_addr == 12'h004;
    assign a_rx   = bus.reg_addr == 12'h008;
    assign a_ctrl = bus.reg_addr == 12'h00C;
    assign a_wm   = bus.reg_addr == 12'h010;
    assign a_stat = bus.reg_addr == 12'h014;
    assign a_ien  = bus.reg_addr == 12'h018;
    assign a_ist  = bus.reg_addr == 12'h01C;

    logic wr_ctrl, wr_tx, wr_ist, rd_rx, tx_rst, rx_rst, div_ok;
    assign wr_ctrl = bus.reg_we && a_ctrl;
    assign wr_tx   = bus.reg_we && a_tx;
    assign wr_ist  = bus.reg_we && a_ist;
    assign rd_rx   = bus.reg_re && a_rx;
    assign tx_rst  = wr_ctrl && bus.reg_wdata[4];
    assign rx_rst  = wr_ctrl && bus.reg_wdata[5];
    assign div_ok  = div_q >= 16'd2;

    logic par_en, par_odd;
`ifdef UART_PARITY_EN
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) {par_odd, par_en} <= 2'b00;
        else if (wr_ctrl) {par_odd, par_en} <= bus.reg_wdata[3:2];
`else
    assign par_en  = 1'b0;
    assign par_odd = 1'b0;
`endif

    // FIFOs: one extra pointer bit separates full from empty
    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [AW:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [6:0]  tx_lvl, rx_lvl;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, tx_ovf, rx_push, rx_pop, rx_ovf, rx_req, rx_ferr;

    assign tx_lvl   = 7'(tx_wp - tx_rp);
    assign rx_lvl   = 7'(rx_wp - rx_rp);
    assign tx_empty = tx_wp == tx_rp;
    assign rx_empty = rx_wp == rx_rp;
    assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
    assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
    assign tx_push  = wr_tx && !tx_full;
    assign tx_ovf   = wr_tx && tx_full;
    assign rx_push  = rx_req && !rx_full;
    assign rx_ovf   = rx_req && rx_full;
    assign rx_pop   = rd_rx && !rx_empty;

    // TX engine
    st_t tx_st, tx_st_n;
    logic [15:0] tx_cnt, tx_cnt_n;
    logic [2:0] tx_bit, tx_bit_n;
    logic [DATA_W-1:0] tx_sh, tx_sh_n;
    logic tx_par, tx_par_n, tx_tick;
    assign tx_tick = tx_cnt == div_q - 16'd1;

    always_comb begin
        tx_st_n  = tx_st;
        tx_cnt_n = tx_cnt + 16'd1;
        tx_bit_n = tx_bit;
        tx_sh_n  = tx_sh;
        tx_par_n = tx_par;
        tx_pop   = 1'b0;
        unique case (tx_st)
            S_IDLE: begin
                tx_cnt_n = '0;
                if (tx_en_q && !tx_empty && div_ok) begin
                    tx_st_n  = S_START;
                    tx_sh_n  = tx_mem[tx_rp[AW-1:0]];
                    tx_par_n = ^tx_mem[tx_rp[AW-1:0]] ^ par_odd;
                    tx_pop   = 1'b1;
                end
            end
            S_START: if (tx_tick) begin
                tx_st_n  = S_DATA;
                tx_cnt_n = '0;
                tx_bit_n = '0;
            end
            S_DATA: if (tx_tick) begin
                tx_cnt_n = '0;
                tx_bit_n = tx_bit + 3'd1;
                tx_sh_n  = tx_sh >> 1;
                if (tx_bit == 3'(DATA_W - 1)) tx_st_n = par_en ? S_PAR : S_STOP;
            end
            S_PAR: if (tx_tick) begin
                tx_st_n  = S_STOP;
                tx_cnt_n = '0;
            end
            S_STOP: if (tx_tick) tx_st_n = S_IDLE;
            default: tx_st_n = S_IDLE;
        endcase
        if (tx_rst || !div_ok) begin
            tx_st_n = S_IDLE;
            tx_pop  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            tx_st  <= S_IDLE;
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_sh  <= '0;
            tx_par <= 1'b0;
        end else begin
            tx_st  <= tx_st_n;
            tx_cnt <= tx_cnt_n;
            tx_bit <= tx_bit_n;
            tx_sh  <= tx_sh_n;
            tx_par <= tx_par_n;
        end

    always_comb begin
        tx_o = 1'b1;
        unique case (tx_st)
            S_START: tx_o = 1'b0;
            S_DATA:  tx_o = tx_sh[0];
            S_PAR:   tx_o = tx_par;
            default: tx_o = 1'b1;
        endcase
    end

    // RX engine; the synchroniser idles high so reset never fakes a start edge
    logic rx_s1, rx_s2, rx_q;
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) {rx_q, rx_s2, rx_s1} <= 3'b111;
        else {rx_q, rx_s2, rx_s1} <= {rx_s2, rx_s1, rx_i};

    st_t rx_st, rx_st_n;
    logic [15:0] rx_cnt, rx_cnt_n;
    logic [2:0] rx_bit, rx_bit_n;
    logic [DATA_W-1:0] rx_sh, rx_sh_n;
    logic rx_pb, rx_pb_n, rx_tick, rx_mid;
    assign rx_tick = rx_cnt == div_q - 16'd1;
    assign rx_mid  = rx_cnt == {1'b0, div_q[15:1]};

    always_comb begin
        rx_st_n  = rx_st;
        rx_cnt_n = rx_cnt + 16'd1;
        rx_bit_n = rx_bit;
        rx_sh_n  = rx_sh;
        rx_pb_n  = rx_pb;
        rx_req   = 1'b0;
        rx_ferr  = 1'b0;
        unique case (rx_st)
            S_IDLE: begin
                rx_cnt_n = '0;
                rx_pb_n  = 1'b0;
                if (rx_en_q && rx_q && !rx_s2) rx_st_n = S_START;
            end
            S_START: begin
                if (rx_mid && rx_s2) rx_st_n = S_IDLE;
                else if (rx_tick) begin
                    rx_st_n  = S_DATA;
                    rx_cnt_n = '0;
                    rx_bit_n = '0;
                end
            end
            S_DATA: begin
                if (rx_mid) rx_sh_n = {rx_s2, rx_sh[DATA_W-1:1]};
                if (rx_tick) begin
                    rx_cnt_n = '0;
                    rx_bit_n = rx_bit + 3'd1;
                    if (rx_bit == 3'(DATA_W - 1)) rx_st_n = par_en ? S_PAR : S_STOP;
                end
            end
            S_PAR: begin
                if (rx_mid) rx_pb_n = rx_s2 ^ (^rx_sh) ^ par_odd;
                if (rx_tick) begin
                    rx_st_n  = S_STOP;
                    rx_cnt_n = '0;
                end
            end
            // Decide at mid-stop so the next start edge is never missed
            S_STOP: if (rx_mid) begin
                rx_st_n = S_IDLE;
                if (!rx_s2 || rx_pb) rx_ferr = 1'b1;
                else rx_req = 1'b1;
            end
            default: rx_st_n = S_IDLE;
        endcase
        if (rx_rst || !div_ok) begin
            rx_st_n = S_IDLE;
            rx_req  = 1'b0;
            rx_ferr = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            rx_st  <= S_IDLE;
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_sh  <= '0;
            rx_pb  <= 1'b0;
        end else begin
            rx_st  <= rx_st_n;
            rx_cnt <= rx_cnt_n;
            rx_bit <= rx_bit_n;
            rx_sh  <= rx_sh_n;
            rx_pb  <= rx_pb_n;
        end

    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wp[AW-1:0]] <= bus.reg_wdata[DATA_W-1:0];
        if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_sh;
    end

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (tx_rst) begin
                tx_wp <= '0;
                tx_rp <= '0;
            end else begin
                if (tx_push) tx_wp <= tx_wp + 1'b1;
                if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            end
            if (rx_rst) begin
                rx_wp <= '0;
                rx_rp <= '0;
            end else begin
                if (rx_push) rx_wp <= rx_wp + 1'b1;
                if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            end
        end

    // Timeout: bit-times of RX idle with unread data, saturating after one fire
    logic [15:0] to_cnt;
    logic [TW-1:0] to_bits;
    logic to_run, to_clr, to_bt, to_fire;
    assign to_clr  = rx_st != S_IDLE || rx_pop || rx_rst || rx_empty;
    assign to_run  = div_ok && to_bits != TW'(TIMEOUT_BITS);
    assign to_bt   = to_cnt == div_q - 16'd1;
    assign to_fire = !to_clr && to_run && to_bt && to_bits == TW'(TIMEOUT_BITS - 1);

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            to_cnt  <= '0;
            to_bits <= '0;
        end else if (to_clr) begin
            to_cnt  <= '0;
            to_bits <= '0;
        end else if (to_run) begin
            to_cnt  <= to_bt ? 16'd0 : to_cnt + 16'd1;
            to_bits <= to_bits + TW'(to_bt);
        end

    logic [4:0] ist;
    assign ist = {tx_empty && tx_st == S_IDLE, err_q, tmo_q,
                  rx_lvl >= {1'b0, rx_wm_q}, tx_lvl <= {1'b0, tx_wm_q}};
    assign {intr_tx_done, intr_rx_err, intr_rx_timeout, intr_rx_wm, intr_tx_wm} = ist & ien_q;

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            div_q   <= '0;
            tx_en_q <= 1'b0;
            rx_en_q <= 1'b0;
            tx_wm_q <= '0;
            rx_wm_q <= '0;
            ien_q   <= '0;
            tmo_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (bus.reg_we && a_div) div_q <= bus.reg_wdata[15:0];
            if (wr_ctrl) {rx_en_q, tx_en_q} <= bus.reg_wdata[1:0];
            if (bus.reg_we && a_wm) begin
                tx_wm_q <= bus.reg_wdata[5:0];
                rx_wm_q <= bus.reg_wdata[13:8];
            end
            if (bus.reg_we && a_ien) ien_q <= bus.reg_wdata[4:0];
            tmo_q   <= to_fire | (tmo_q & ~(wr_ist & bus.reg_wdata[2]));
            err_q   <= tx_ovf | rx_ovf | rx_ferr | (err_q & ~(wr_ist & bus.reg_wdata[3]));
            rdata_q <= bus.reg_re ? rd_val : 32'd0;
        end

    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            a_div:  rd_val = {16'd0, div_q};
            a_rx:   rd_val = rx_empty ? 32'd0 : 32'(rx_mem[rx_rp[AW-1:0]]);
            a_ctrl: rd_val = {28'd0, par_odd, par_en, rx_en_q, tx_en_q};
            a_wm:   rd_val = {18'd0, rx_wm_q, 2'd0, tx_wm_q};
            a_stat: rd_val = {14'd0, rx_st != S_IDLE, tx_st != S_IDLE,
                              1'b0, rx_lvl, 1'b0, tx_lvl};
            a_ien:  rd_val = {27'd0, ien_q};
            a_ist:  rd_val = {27'd0, ist};
            default: rd_val = '0;
        endcase
    end

    assign bus.reg_rdata = rdata_q;
endmodule

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
Parametrised successor UART peripheral: a register-mapped full-duplex UART with integrated TX/RX bit engines, configurable data width, FIFO depth, watermark interrupts, RX timeout and error reporting. It sits behind the peripheral register bus (reg_addr/reg_wdata/reg_we/reg_re) and drives tx_o and samples rx_i on the pad side. Unlike the previous generation, RX takes rx_i directly (not looped from tx_o), FIFO pops happen only on a qualified read, and status is fully readable.

Parameters:
DATA_W, 8, data bits per frame; legal 5..8; unused upper register bits read 0
FIFO_DEPTH, 8, entries per TX and RX FIFO; power of 2, 2..64
TIMEOUT_BITS, 32, idle bit-times after last RX stop bit before the timeout interrupt fires

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset; asynchronous assert, active-low
reg_wdata  input  32  write data
reg_addr  input  12  byte address
reg_we  input  1  write strobe, one cycle per access
reg_re  input  1  read strobe, one cycle per access
reg_rdata  output  32  read data, valid one cycle after reg_re
rx_i  input  1  serial in, asynchronous to clk_i
tx_o  output  1  serial out, idle high
intr_tx_wm  output  1  TX level <= TX watermark
intr_rx_wm  output  1  RX level >= RX watermark
intr_rx_timeout  output  1  RX timeout
intr_rx_err  output  1  framing/overflow (or parity) error
intr_tx_done  output  1  TX FIFO empty and shifter idle

Behaviour:
- Reset: tx_o=1, reg_rdata=0, all intr_*=0, FIFOs empty, all registers 0, both FSMs IDLE.
- Register map: 0x000 DIV[15:0] clocks per bit; 0x004 TXDATA (W: push); 0x008 RXDATA (R: pop, returns 0 if empty); 0x00C CTRL [0]tx_en [1]rx_en [2]par_en [3]par_odd [4]txrst [5]rxrst; 0x010 WM [5:0]tx_wm [13:8]rx_wm; 0x014 STATUS (RO) [6:0]tx_lvl [14:8]rx_lvl [16]tx_busy [17]rx_busy; 0x018 INTR_EN [4:0]; 0x01C INTR_STATE [4:0], W1C for sticky bits. Unmapped write: ignored. Unmapped read: 0.
- Interrupt output = INTR_STATE bit AND INTR_EN bit. wm/done are level bits; timeout/err are sticky until W1C.
- txrst/rxrst: self-clearing; empty the FIFO the same cycle, abort the FSM to IDLE, tx_o=1.
- TX FSM IDLE->START->DATA(DATA_W bits, LSB first)->[PARITY]->STOP->IDLE. Each state lasts DIV cycles. It leaves IDLE when tx_en=1, FIFO non-empty and DIV>=2; the byte pops on that transition. If tx_en is cleared mid-frame, the current frame completes.
- RX: rx_i passes through a 2-flop synchroniser. IDLE->START on a falling edge when rx_en=1. START rechecks at DIV/2; if high, it returns to IDLE as a glitch. DATA bits are sampled at mid-bit. STOP: a low sample sets frame error and the byte is discarded; otherwise the byte is pushed. If the FIFO is full, the byte is dropped and rx_overflow is set (error).
- Timeout counter: counts bit-times while RX is IDLE and the RX FIFO is non-empty. It resets on any start bit or pop. It fires once at TIMEOUT_BITS.
- Simultaneous push and pop on a FIFO is allowed; level is unchanged. TXDATA write when full: dropped, tx_overflow sets err. Pop when empty: no level change.
- Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. full = MSB differ, rest equal.
- DIV<2: both FSMs are held in IDLE.

Optional Feature:
UART_PARITY_EN: when defined, a PARITY state is inserted when CTRL.par_en=1: even parity, or odd if par_odd=1. An RX mismatch discards the byte and sets err. Without the macro, par_en/par_odd read 0, writes are ignored, and no parity logic is built.

Test Plan:
- DIV=16, tx_en=1, write 0xA5 -> tx_o low 16 cycles, then 1,0,1,0,0,1,0,1 (16 cycles each), stop high; intr_tx_done after the stop bit.
- Loop tx_o to rx_i, rx_en=1, send 0x3C -> RXDATA read returns 0x3C one cycle after reg_re; rx_lvl returns 0.
- Push FIFO_DEPTH+1 bytes with tx_en=0 -> tx_lvl=8; the 9th is dropped; INTR_STATE err=1; W1C clears it.
- rx_wm=4, receive 4 bytes -> intr_rx_wm rises after the 4th stop; idle 32 bit-times -> intr_rx_timeout=1.
- Drive stop bit low on rx_i -> no push, err=1. rst_ni low mid-frame -> tx_o=1 immediately, all levels 0.
- With UART_PARITY_EN, par_en=1, par_odd=1, frame 0x01 with bad parity -> byte discarded, err=1.
